// File: rtl/alu_mp_seq_pkg.sv
// Shared encodings for the multi-precision ALU sequencer: command opcodes,
// alu_top function selects and sequencer FSM states.
package alu_mp_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOGIC = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mp_seq_flags.sv
// Inter-word carry chain, running zero accumulator and final-word flag capture
// for alu_mp_seq; everything advances on the stage-2 load strobe.
module alu_mp_seq_flags (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic load,
    input  logic last,
    input  logic is_sub,
    input  logic is_logic,
    input  logic alu_C,
    input  logic alu_V,
    input  logic alu_N,
    input  logic alu_Z,
    output logic first,
    output logic carry_q,
    output logic out_c,
    output logic out_v,
    output logic out_n,
    output logic out_z
);

    logic first_reg;
    logic carry_reg;
    logic z_acc_reg;
    logic out_c_reg;
    logic out_v_reg;
    logic out_n_reg;
    logic out_z_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_reg <= 1'b0;
            carry_reg <= 1'b0;
            z_acc_reg <= 1'b0;
            out_c_reg <= 1'b0;
            out_v_reg <= 1'b0;
            out_n_reg <= 1'b0;
            out_z_reg <= 1'b0;
        end else if (start) begin
            first_reg <= 1'b1;
        end else if (load) begin
            first_reg <= 1'b0;
            // carry_q is kept in Cin polarity: for SUB, Cin=1 means no borrow
            carry_reg <= is_sub ? ~alu_C : alu_C;
            z_acc_reg <= first_reg ? alu_Z : (z_acc_reg & alu_Z);
            if (last) begin
                out_c_reg <= is_logic ? 1'b1 : alu_C;
                out_v_reg <= alu_V;
                out_n_reg <= alu_N;
                out_z_reg <= first_reg ? alu_Z : (z_acc_reg & alu_Z);
            end
        end
    end

    assign first   = first_reg;
    assign carry_q = carry_reg;
    assign out_c   = out_c_reg;
    assign out_v   = out_v_reg;
    assign out_n   = out_n_reg;
    assign out_z   = out_z_reg;

endmodule

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer wrapped around alu_top: streams N operand words LSW
// first, chains carry/borrow and reports aggregate flags. Optional perf
// counters are enabled with ALU_MP_SEQ_PERF_EN.
module alu_mp_seq
    import alu_mp_seq_pkg::*;
#(
    parameter int ALU_WIDTH = 32,
    parameter int MAX_WORDS = 8,
    parameter int CNT_W     = $clog2(MAX_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [3:0]           cmd_s,
    input  logic [CNT_W-1:0]     cmd_nwords,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_WIDTH-1:0] in_a,
    input  logic [ALU_WIDTH-1:0] in_b,
    output logic [ALU_WIDTH-1:0] alu_opA,
    output logic [ALU_WIDTH-1:0] alu_opB,
    output logic [3:0]           alu_S,
    output logic                 alu_M,
    output logic                 alu_Cin,
    input  logic [ALU_WIDTH-1:0] alu_DO,
    input  logic                 alu_C,
    input  logic                 alu_V,
    input  logic                 alu_N,
    input  logic                 alu_Z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALU_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 out_c,
    output logic                 out_v,
    output logic                 out_n,
    output logic                 out_z
`ifdef ALU_MP_SEQ_PERF_EN
    ,
    output logic [15:0]          perf_cmds,
    output logic [15:0]          perf_stall
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e                 state_reg, state_next;
    op_e                    op_reg;
    logic [3:0]             s_reg;
    logic [CNT_W-1:0]       nwords_reg;
    logic [CNT_W-1:0]       in_idx_reg;
    logic                   in_done_reg;
    logic                   op_valid_reg;
    logic [ALU_WIDTH-1:0]   op_a_reg, op_b_reg;
    logic [CNT_W-1:0]       ld_idx_reg;
    logic                   out_valid_reg;
    logic                   out_last_reg;
    logic [ALU_WIDTH-1:0]   out_data_reg;

    logic cmd_fire, in_fire, out_fire, load, ld_last, first, carry_q;

    assign cmd_ready = (state_reg == IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign load      = op_valid_reg && (!out_valid_reg || out_ready);
    // in_done_reg replaces a count>nwords compare so a full-width nwords never overflows
    assign in_ready  = (state_reg == RUN) && !in_done_reg && (!op_valid_reg || load);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_reg && out_ready;
    assign ld_last   = (ld_idx_reg == nwords_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_fire) state_next = RUN;
            RUN:     if (out_fire && out_last_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= OP_ADD;
            s_reg         <= 4'b0;
            nwords_reg    <= '0;
            in_idx_reg    <= '0;
            in_done_reg   <= 1'b0;
            op_valid_reg  <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            ld_idx_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (cmd_fire) begin
                op_reg      <= (op_e'(cmd_op) == OP_RSVD) ? OP_ADD : op_e'(cmd_op);
                s_reg       <= cmd_s;
                nwords_reg  <= cmd_nwords;
                in_idx_reg  <= '0;
                in_done_reg <= 1'b0;
                ld_idx_reg  <= '0;
            end
            if (in_fire) begin
                op_a_reg   <= in_a;
                op_b_reg   <= in_b;
                in_idx_reg <= in_idx_reg + CNT_ONE;
                if (in_idx_reg == nwords_reg) in_done_reg <= 1'b1;
            end
            if (in_fire)   op_valid_reg <= 1'b1;
            else if (load) op_valid_reg <= 1'b0;
            if (load) begin
                out_data_reg <= alu_DO;
                out_last_reg <= ld_last;
                ld_idx_reg   <= ld_idx_reg + CNT_ONE;
            end
            if (load)          out_valid_reg <= 1'b1;
            else if (out_fire) out_valid_reg <= 1'b0;
        end
    end

    always_comb begin
        alu_S   = S_ADD;
        alu_M   = 1'b1;
        alu_Cin = first ? 1'b0 : carry_q;
        case (op_reg)
            OP_SUB: begin
                alu_S   = S_SUB;
                alu_Cin = first ? 1'b1 : carry_q;
            end
            OP_LOGIC: begin
                alu_S   = s_reg;
                alu_M   = 1'b0;
                alu_Cin = 1'b1;
            end
            default: ;
        endcase
    end

    alu_mp_seq_flags u_flags (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (cmd_fire),
        .load     (load),
        .last     (ld_last),
        .is_sub   (op_reg == OP_SUB),
        .is_logic (op_reg == OP_LOGIC),
        .alu_C    (alu_C),
        .alu_V    (alu_V),
        .alu_N    (alu_N),
        .alu_Z    (alu_Z),
        .first    (first),
        .carry_q  (carry_q),
        .out_c    (out_c),
        .out_v    (out_v),
        .out_n    (out_n),
        .out_z    (out_z)
    );

    assign alu_opA   = op_a_reg;
    assign alu_opB   = op_b_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

`ifdef ALU_MP_SEQ_PERF_EN
    logic [15:0] perf_cmds_reg, perf_stall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cmds_reg  <= 16'h0;
            perf_stall_reg <= 16'h0;
        end else begin
            if (out_fire && out_last_reg && perf_cmds_reg != 16'hFFFF)
                perf_cmds_reg <= perf_cmds_reg + 16'h1;
            if (out_valid_reg && !out_ready && perf_stall_reg != 16'hFFFF)
                perf_stall_reg <= perf_stall_reg + 16'h1;
        end
    end

    assign perf_cmds  = perf_cmds_reg;
    assign perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_alu_mp_seq.sv
// Directed bench for alu_mp_seq with a behavioural alu_top stand-in closing the
// loop between the sequencer's alu_* outputs and alu_DO/C/V/N/Z inputs.
module tb_alu_mp_seq;
    import alu_mp_seq_pkg::*;

    localparam int W  = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [3:0]    cmd_s;
    logic [CW-1:0] cmd_nwords;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [W-1:0]  alu_opA, alu_opB;
    logic [3:0]    alu_S;
    logic          alu_M, alu_Cin;
    logic [W-1:0]  alu_DO;
    logic          alu_C, alu_V, alu_N, alu_Z;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic          out_last, out_c, out_v, out_n, out_z;
`ifdef ALU_MP_SEQ_PERF_EN
    logic [15:0]   perf_cmds, perf_stall;
`endif

    always #5 clk = ~clk;

    alu_mp_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_s(cmd_s), .cmd_nwords(cmd_nwords),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_S(alu_S), .alu_M(alu_M),
        .alu_Cin(alu_Cin), .alu_DO(alu_DO), .alu_C(alu_C), .alu_V(alu_V),
        .alu_N(alu_N), .alu_Z(alu_Z),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_c(out_c), .out_v(out_v), .out_n(out_n),
        .out_z(out_z)
`ifdef ALU_MP_SEQ_PERF_EN
        , .perf_cmds(perf_cmds), .perf_stall(perf_stall)
`endif
    );

    // alu_top stand-in: SUB reports borrow-out on C, logic mode reports C=0
    logic [W:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        alu_DO  = '0;
        alu_C   = 1'b0;
        alu_V   = 1'b0;
        if (alu_M) begin
            if (alu_S == 4'b0110) begin
                alu_sum = {1'b0, alu_opA} + {1'b0, ~alu_opB} + {{W{1'b0}}, alu_Cin};
                alu_DO  = alu_sum[W-1:0];
                alu_C   = ~alu_sum[W];
                alu_V   = (alu_opA[W-1] != alu_opB[W-1]) && (alu_DO[W-1] != alu_opA[W-1]);
            end else begin
                alu_sum = {1'b0, alu_opA} + {1'b0, alu_opB} + {{W{1'b0}}, alu_Cin};
                alu_DO  = alu_sum[W-1:0];
                alu_C   = alu_sum[W];
                alu_V   = (alu_opA[W-1] == alu_opB[W-1]) && (alu_DO[W-1] != alu_opA[W-1]);
            end
        end else begin
            case (alu_S)
                4'b0110: alu_DO = alu_opA ^ alu_opB;
                4'b1011: alu_DO = alu_opA & alu_opB;
                4'b1110: alu_DO = alu_opA | alu_opB;
                default: alu_DO = ~alu_opA;
            endcase
        end
        alu_N = alu_DO[W-1];
        alu_Z = (alu_DO == '0);
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [W-1:0] va [0:7];
    logic [W-1:0] vb [0:7];
    logic [W-1:0] rd [0:7];
    logic         rl [0:7];
    int           out_cnt;
    logic         fc, fv, fn, fz, done;
    logic         in_block_seen, cmd_ready_bad;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [3:0] s, input logic [CW-1:0] nw);
        logic fired;
        fired      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_s      = s;
        cmd_nwords = nw;
        for (int i = 0; i < 20 && !fired; i++) begin
            @(negedge clk);
            if (cmd_ready) fired = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check1("cmd_accept", fired, 1'b1);
    endtask

    // Feeds nw words from va/vb and collects results; optionally drops out_ready
    // for stall_len cycles after the first result word is taken.
    task automatic run_words(input int nw, input int stall_len);
        int  in_idx, stall_rem, cyc;
        logic in_f, out_f;
        in_idx = 0; stall_rem = 0; cyc = 0;
        out_cnt = 0; done = 1'b0;
        in_block_seen = 1'b0; cmd_ready_bad = 1'b0;
        out_ready = 1'b1;
        while (!done && cyc < 200) begin
            in_valid = (in_idx < nw);
            in_a     = (in_idx < nw) ? va[in_idx] : '0;
            in_b     = (in_idx < nw) ? vb[in_idx] : '0;
            @(negedge clk);
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (in_valid && !in_ready && out_valid && !out_ready) in_block_seen = 1'b1;
            if (cmd_ready) cmd_ready_bad = 1'b1;
            if (out_f && out_cnt < 8) begin
                rd[out_cnt] = out_data;
                rl[out_cnt] = out_last;
                $display("out word %0d data=%h last=%b c=%b v=%b n=%b z=%b",
                         out_cnt, out_data, out_last, out_c, out_v, out_n, out_z);
                if (out_last) begin
                    fc = out_c; fv = out_v; fn = out_n; fz = out_z;
                    done = 1'b1;
                end
                out_cnt++;
            end
            @(posedge clk); #1;
            if (in_f) in_idx++;
            if (stall_rem > 0) begin
                stall_rem--;
                out_ready = (stall_rem == 0);
            end else if (out_f && out_cnt == 1 && stall_len > 0 && !done) begin
                out_ready = 1'b0;
                stall_rem = stall_len;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check1("cmd_done_in_budget", done, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_s = 4'b0;
        cmd_nwords = '0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_alu_opA", alu_opA, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two-word ADD with carry across the word boundary
        va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000001;
        va[1] = 32'h00000001; vb[1] = 32'h00000000;
        issue_cmd(2'b00, 4'h0, 3'd1);
        check("add_alu_S", {28'h0, alu_S}, 32'h9);
        check1("add_alu_M", alu_M, 1'b1);
        check1("add_alu_Cin_first", alu_Cin, 1'b0);
        run_words(2, 0);
        check("add2_cnt", out_cnt, 2);
        check("add2_w0", rd[0], 32'h00000000);
        check1("add2_w0_last", rl[0], 1'b0);
        check("add2_w1", rd[1], 32'h00000002);
        check1("add2_w1_last", rl[1], 1'b1);
        check("add2_cvnz", {28'h0, fc, fv, fn, fz}, 32'h0);

        // 2: one-word SUB producing a borrow
        va[0] = 32'h00000001; vb[0] = 32'h00000002;
        issue_cmd(2'b01, 4'h0, 3'd0);
        check("sub_alu_S", {28'h0, alu_S}, 32'h6);
        check1("sub_alu_Cin_first", alu_Cin, 1'b1);
        run_words(1, 0);
        check("sub1_w0", rd[0], 32'hFFFFFFFF);
        check("sub1_cvnz", {28'h0, fc, fv, fn, fz}, 32'h0000000A);

        // 3: two-word SUB, borrow chained into the upper word
        va[0] = 32'h00000000; vb[0] = 32'h00000001;
        va[1] = 32'h00000001; vb[1] = 32'h00000000;
        issue_cmd(2'b01, 4'h0, 3'd1);
        run_words(2, 0);
        check("sub2_w0", rd[0], 32'hFFFFFFFF);
        check("sub2_w1", rd[1], 32'h00000000);
        check("sub2_cvnz", {28'h0, fc, fv, fn, fz}, 32'h0);

        // 4: LOGIC XOR
        va[0] = 32'hFFFF0000; vb[0] = 32'hFF00FF00;
        issue_cmd(2'b10, 4'b0110, 3'd0);
        check1("xor_alu_Cin", alu_Cin, 1'b1);
        check1("xor_alu_M", alu_M, 1'b0);
        check("xor_alu_S", {28'h0, alu_S}, 32'h6);
        run_words(1, 0);
        check("xor_w0", rd[0], 32'h00FFFF00);
        check1("xor_last", rl[0], 1'b1);
        check1("xor_c", fc, 1'b1);
        check1("xor_z", fz, 1'b0);

        // 5: four-word zero ADD with downstream back-pressure
        for (int i = 0; i < 4; i++) begin va[i] = '0; vb[i] = '0; end
        issue_cmd(2'b00, 4'h0, 3'd3);
        run_words(4, 3);
        check("stall_cnt", out_cnt, 4);
        check("stall_w0", rd[0], 32'h0);
        check("stall_w3", rd[3], 32'h0);
        check1("stall_w2_last", rl[2], 1'b0);
        check1("stall_w3_last", rl[3], 1'b1);
        check1("stall_in_ready_drop", in_block_seen, 1'b1);
        check1("stall_cmd_ready_low", cmd_ready_bad, 1'b0);
        check1("stall_z", fz, 1'b1);
        check1("stall_c", fc, 1'b0);
        @(negedge clk);
        check1("idle_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;

        // 6: reset in the middle of a four-word ADD
        issue_cmd(2'b00, 4'h0, 3'd3);
        in_valid = 1'b1; in_a = 32'h1; in_b = 32'h1;
        @(posedge clk); #1;
        in_a = 32'h2; in_b = 32'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check1("mid_rst_out_valid", out_valid, 1'b0);
        check1("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check1("mid_rst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check1("mid_rst_quiet", out_valid, 1'b0);
        va[0] = 32'h5; vb[0] = 32'h7;
        issue_cmd(2'b00, 4'h0, 3'd0);
        run_words(1, 0);
        check("post_rst_sum", rd[0], 32'h0000000C);
        check1("post_rst_last", rl[0], 1'b1);

        // reserved opcode executes as ADD
        va[0] = 32'h3; vb[0] = 32'h4;
        issue_cmd(2'b11, 4'h0, 3'd0);
        run_words(1, 0);
        check("rsvd_as_add", rd[0], 32'h00000007);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/alu_mp_seq.md
Name: alu_mp_seq

Overview:
Multi-precision operation sequencer that sits directly upstream of alu_top and downstream of it for the result. It accepts one command describing an N-word operation, then streams operand words into alu_top least-significant word first. It feeds the carry or borrow of each word back into Cin for the next word and streams the result words out. It reports aggregate C/V/N/Z flags with the last result word.

Parameters:
ALU_WIDTH, 32, word width; must match the alu_top instance.
MAX_WORDS, 8, maximum words per command (power of two, ≥2).
CNT_W, $clog2(MAX_WORDS), width of the word-count field and counter.

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when both valid and ready are high
cmd_op  input  2  00 ADD, 01 SUB, 10 LOGIC, 11 reserved
cmd_s  input  4  logic function code; used only when cmd_op=LOGIC
cmd_nwords  input  CNT_W  word count minus 1 (0 means 1 word)
in_valid  input  1  operand word offered
in_ready  output  1  operand word accepted
in_a  input  ALU_WIDTH  operand A word
in_b  input  ALU_WIDTH  operand B word
alu_opA  output  ALU_WIDTH  to alu_top opA
alu_opB  output  ALU_WIDTH  to alu_top opB
alu_S  output  4  to alu_top S
alu_M  output  1  to alu_top M
alu_Cin  output  1  to alu_top Cin
alu_DO  input  ALU_WIDTH  from alu_top DO
alu_C  input  1  from alu_top C
alu_V  input  1  from alu_top V
alu_N  input  1  from alu_top N
alu_Z  input  1  from alu_top Z
out_valid  output  1  result word valid
out_ready  input  1  downstream accepts
out_data  output  ALU_WIDTH  result word
out_last  output  1  marks the final word of a command
out_c  output  1  final carry (ADD) or borrow (SUB); 1 for LOGIC
out_v  output  1  signed overflow of the final word
out_n  output  1  MSB of the final word
out_z  output  1  1 when every result word of the command is zero

Behaviour:
- Reset: on rst_n=0 at a clock edge, all state clears. Results:
  - state=IDLE; cmd_ready=1; in_ready=0; out_valid=0.
  - All data, flag and alu_* registers are 0.
  - Reset mid-command discards all in-flight words; nothing is emitted afterwards.
- FSM: IDLE -> RUN on cmd fire; RUN -> IDLE on out fire with out_last=1.
  - cmd_ready=1 only in IDLE.
  - Commands offered while busy stall and are not dropped.
- Command capture: op, s, nwords are latched; the word counter clears; the first flag is set.
  - cmd_op=11 is executed as ADD.
- Stage 1 (operand register): captures in_a/in_b on in fire and sets op_valid.
  - in_ready = RUN && words_accepted ≤ nwords && (!op_valid || stage-2 load this cycle).
  - alu_opA/alu_opB come from stage-1 registers.
  - alu_S, alu_M, alu_Cin are combinational from the latched op:
    - ADD: S=1001, M=1, Cin = first ? 0 : carry_q.
    - SUB: S=0110, M=1, Cin = first ? 1 : carry_q.
    - LOGIC: S=cmd_s, M=0, Cin=1.
- alu_top contract for SUB: C = borrow-out including the borrow-in (Cin=0 means borrow-in).
- Stage 2 (result register): loads alu_DO when op_valid && (!out_valid || out_ready).
  - carry_q <= (SUB ? ~alu_C : alu_C); first is cleared.
  - z_acc <= (first_result ? alu_Z : z_acc & alu_Z).
  - out_last=1 when the loaded word index == nwords.
  - On the last word: out_c=alu_C (1 for LOGIC), out_v=alu_V, out_n=alu_N, out_z=z_acc & alu_Z.
  - Flags are meaningful only when out_last=1.
- Latency: operand fire to out_valid is 1 cycle.
- Throughput is one word per cycle when out_ready is held high.
- out_data and flags hold stable while out_valid && !out_ready.
- Surplus words beyond nwords are not accepted (in_ready=0).
- Counter wrap: nwords=MAX_WORDS-1 with a full-width counter. The compare uses the index, never count+1, so there is no overflow.

Optional Feature:
ALU_MP_SEQ_PERF_EN:
- When defined, adds output perf_cmds[15:0], the count of completed commands (last-word out fires).
- Also adds perf_stall[15:0], the count of cycles with out_valid && !out_ready.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist.

Decomposition:
- alu_mp_seq_pkg holds:
  - OP_ADD/OP_SUB/OP_LOGIC/OP_RSVD encodings.
  - S_ADD=4'b1001 and S_SUB=4'b0110.
  - State encodings IDLE/RUN.
- One sub-module, alu_mp_seq_flags: carry_q, z_acc and final-flag capture, driven by the stage-2 load strobe.

Test Plan:
1. ADD, 2 words: A={00000001,FFFFFFFF}, B={00000000,00000001}.
   -> Word0 out 00000000 (out_last=0); word1 out 00000002 with out_last=1, C=0, V=0, N=0, Z=0.
2. SUB, 1 word: 00000001-00000002.
   -> out FFFFFFFF, out_c=1, out_n=1, out_z=0, out_v=0.
3. SUB, 2 words: {00000001,00000000}-{00000000,00000001}.
   -> Out FFFFFFFF then 00000000; final C=0, Z=0 (word0 non-zero).
4. LOGIC XOR (S=0110), 1 word: ffff0000 ^ ff00ff00.
   -> out 00ffff00, alu_Cin=1, alu_M=0, out_c=1.
5. ADD, 4 words, all zero; out_ready low for 3 cycles after the first word.
   -> in_ready drops, no word lost or duplicated; out_z=1; cmd_ready=0 until the last fire.
6. rst_n low for 1 cycle after word 1 of a 4-word ADD.
   -> Next cycle: IDLE, out_valid=0; a new 1-word ADD 5+7 gives 0000000C.
